// File: rtl/olive_std_core_nios2_fast_cpu_mult_combine.sv
// Reduces the three 16x16 partial products from the fast-core multiply cell to the low 32 bits
// of the 32x32 product. Define MUL_COMBINE_OUTREG_EN to add a registered output stage.
module olive_std_core_nios2_fast_cpu_mult_combine #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      M_mul_cell_p1,
  input  logic [31:0]      M_mul_cell_p2,
  input  logic [31:0]      M_mul_cell_p3,
  input  logic             M_mul_valid,
  input  logic [TAG_W-1:0] M_mul_tag,
  input  logic             A_en,
  input  logic             A_flush,
  output logic [31:0]      A_mul_result,
  output logic             A_mul_valid,
  output logic [TAG_W-1:0] A_mul_tag,
  output logic             A_mul_busy
);

  logic [31:0]      s1_lo;
  logic [15:0]      s1_x;
  logic             s1_v;
  logic [TAG_W-1:0] s1_tag;
  logic [15:0]      cross_sum;
  logic [31:0]      s1_result;

  // Only the low halves of the cross products land inside the low 32 bits.
  assign cross_sum = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
  assign s1_result = s1_lo + {s1_x, 16'h0000};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_lo  <= '0;
      s1_x   <= '0;
      s1_v   <= 1'b0;
      s1_tag <= '0;
    end else begin
      if (A_flush)
        s1_v <= 1'b0;
      else if (A_en)
        s1_v <= M_mul_valid;
      if (A_en && !A_flush) begin
        s1_lo  <= M_mul_cell_p1;
        s1_x   <= cross_sum;
        s1_tag <= M_mul_tag;
      end
    end
  end

`ifdef MUL_COMBINE_OUTREG_EN
  logic [31:0]      s2_result;
  logic             s2_v;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_result <= '0;
      s2_v      <= 1'b0;
      s2_tag    <= '0;
    end else begin
      if (A_flush)
        s2_v <= 1'b0;
      else if (A_en)
        s2_v <= s1_v;
      if (A_en && !A_flush) begin
        s2_result <= s1_result;
        s2_tag    <= s1_tag;
      end
    end
  end

  assign A_mul_result = s2_result;
  assign A_mul_valid  = s2_v;
  assign A_mul_tag    = s2_tag;
  assign A_mul_busy   = s1_v | s2_v;
`else
  assign A_mul_result = s1_result;
  assign A_mul_valid  = s1_v;
  assign A_mul_tag    = s1_tag;
  assign A_mul_busy   = s1_v;
`endif

endmodule
